// File: rtl/debounce_sync_if.sv
// rtl/debounce_sync_if.sv - input-conditioning bus between pin side and register side
//
// Purpose: bundles the raw pin input with the debounced level and its strobes.
// Signals:
//   din   raw asynchronous input from the board pin
//   dout  debounced, clock-synchronous level
//   rise  one-cycle strobe on dout 0->1
//   fall  one-cycle strobe on dout 1->0
// Modports:
//   master  drives din, observes the conditioned outputs (pin side / bench)
//   slave   the conditioner itself
interface debounce_sync_if;
  logic din;
  logic dout;
  logic rise;
  logic fall;

  modport master (
    output din,
    input  dout,
    input  rise,
    input  fall
  );

  modport slave (
    input  din,
    output dout,
    output rise,
    output fall
  );
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with async active-low clear
//
// Purpose: brings an asynchronous level into the clk domain; q lags d by two edges.
// Ports:
//   clk  rising-edge clock
//   clr  asynchronous active-low clear, forces both stages to 0
//   d    asynchronous input
//   q    synchronized output (second stage)
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronizer plus stability-counting debouncer
//
// Purpose: turns a bouncing pin into a clean level with rise/fall strobes.
// A new level is accepted only after the synchronized input has held it for
// STABLE_CNT+1 consecutive edges; any bounce back abandons the attempt.
// Ports:
//   clk  rising-edge clock
//   clr  asynchronous active-low reset
//   bus  debounce_sync_if.slave: din in; dout, rise, fall out (all flop outputs)
// Parameters:
//   STABLE_CNT  stable cycles required (>= 2)
//   CNT_W       counter width, 2**CNT_W > STABLE_CNT-1
module debounce_sync #(
  parameter int STABLE_CNT = 50000,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               clr,
  debounce_sync_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

  logic             s2;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_2ff u_sync (
    .clk (clk),
    .clr (clr),
    .d   (bus.din),
    .q   (s2)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (s2) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!s2) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.dout = dout_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - directed vector bench for debounce_sync
module tb_debounce_sync;

  localparam int STABLE_CNT = 4;
  localparam int CNT_W      = 3;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #20 clk = ~clk;

  debounce_sync_if bus_if ();

  debounce_sync #(
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if)
  );

  // Downstream D flip-flop stage with pre/clr held inactive.
  logic ff_q = 1'b0;
  logic ff_qn;
  always @(posedge clk) ff_q <= bus_if.dout;
  assign ff_qn = ~ff_q;

  typedef struct {
    logic din;
    logic dout;
    logic rise;
    logic fall;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic add(input logic din, input int n, input logic dout,
                     input logic rise, input logic fall);
    vec_t v;
    v.din  = din;
    v.dout = dout;
    v.rise = rise;
    v.fall = fall;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic dout,
                       input logic rise, input logic fall);
    nvec++;
    if (bus_if.dout !== dout || bus_if.rise !== rise || bus_if.fall !== fall) begin
      nerr++;
      $display("FAIL %s: dout/rise/fall=%b%b%b expected %b%b%b", name,
               bus_if.dout, bus_if.rise, bus_if.fall, dout, rise, fall);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset hold with din=1: outputs stay low throughout.
    bus_if.din = 1'b1;
    clr        = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #10;
      check("reset_hold", 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    clr = 1'b1;

    // Edges 1-10: din held high after release, rise at edge 7.
    add(1, 6, 0, 0, 0);
    add(1, 1, 1, 1, 0);
    add(1, 3, 1, 0, 0);
    // Edges 11-20: falling edge, fall at edge 17.
    add(0, 6, 1, 0, 0);
    add(0, 1, 0, 0, 1);
    add(0, 3, 0, 0, 0);
    // Edges 21-34: 4-cycle pulse rejected.
    add(1, 4, 0, 0, 0);
    add(0, 10, 0, 0, 0);
    // Edges 35-52: 5-cycle pulse accepted (rise at 41), then released (fall at 46).
    add(1, 5, 0, 0, 0);
    add(0, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0);
    add(0, 4, 1, 0, 0);
    add(0, 1, 0, 0, 1);
    add(0, 6, 0, 0, 0);
    // Edges 53-66: bounce 1,1,0 then stable 1; rise at edge 62.
    add(1, 2, 0, 0, 0);
    add(0, 1, 0, 0, 0);
    add(1, 6, 0, 0, 0);
    add(1, 1, 1, 1, 0);
    add(1, 4, 1, 0, 0);
    // Edges 67-70: start a fall, leaving the FSM mid-WAIT_LOW.
    add(0, 4, 1, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      bus_if.din = tbl[i].din;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i + 1), tbl[i].dout, tbl[i].rise, tbl[i].fall);
    end

    // Async reset mid-wait: dout drops without a clock edge, no strobe.
    #9;
    clr = 1'b0;
    #2;
    check("async_clr", 1'b0, 1'b0, 1'b0);
    #7;
    clr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus_if.din = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("post_clr%0d", k + 1), 1'b0, 1'b0, 1'b0);
    end

    // Downstream stage: 3-cycle bounce then stable high; Q lags dout by one edge.
    for (int k = 1; k <= 12; k++) begin
      bus_if.din = (k == 2) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("dff%0d", k), (k >= 9), (k == 9), 1'b0);
      nvec++;
      if (ff_q !== (k >= 10) || ff_qn !== !(k >= 10)) begin
        nerr++;
        $display("FAIL dff_q%0d: q/qn=%b%b expected %b%b", k, ff_q, ff_qn,
                 (k >= 10), !(k >= 10));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
